// File: rtl/reg_file_pkg.sv
// Shared constants and word type for the register file and the SPI slave
// that sits in front of it.
package reg_file_pkg;

   localparam int REG_DATA_WIDTH   = 8;
   localparam int REG_LENGTH       = 256;
   localparam int REG_ADDRESS_SIZE = 8;

   typedef logic [REG_DATA_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_if.sv
// Single-port register file bus: one address for writes and registered reads.
// The master drives address/data/write-enable; the slave returns o_data.
interface reg_file_if
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH   = REG_DATA_WIDTH,
   parameter int ADDRESS_SIZE = REG_ADDRESS_SIZE
) ();

   logic [ADDRESS_SIZE-1:0] i_address;
   logic [DATA_WIDTH-1:0]   i_data;
   logic                    i_wr_en;
   logic [DATA_WIDTH-1:0]   o_data;

   modport master (
      output i_address,
      output i_data,
      output i_wr_en,
      input  o_data
   );

   modport slave (
      input  i_address,
      input  i_data,
      input  i_wr_en,
      output o_data
   );

endinterface

// File: rtl/reg_file.sv
// Single-port synchronous register file with registered read port.
// Define REG_FILE_WRITE_THROUGH_EN to also load o_data on in-range writes.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH   = REG_DATA_WIDTH,
   parameter int LENGTH       = REG_LENGTH,
   parameter int ADDRESS_SIZE = REG_ADDRESS_SIZE
) (
   input logic        i_clk,
   input logic        i_rst_n,
   reg_file_if.slave  bus
);

   localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   // One extra bit so LENGTH == 2**ADDRESS_SIZE is representable.
   localparam logic [ADDRESS_SIZE:0] LEN_LIMIT = LENGTH[ADDRESS_SIZE:0];

   logic [DATA_WIDTH-1:0] mem_q [LENGTH];
   logic [DATA_WIDTH-1:0] o_data_q;
   logic [DATA_WIDTH-1:0] o_data_d;

   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             wr_hit;
   logic [DATA_WIDTH-1:0] rd_word;

   assign in_range = {1'b0, bus.i_address} < LEN_LIMIT;
   assign idx      = bus.i_address[IDX_W-1:0];
   assign wr_hit   = bus.i_wr_en & in_range;

   always_comb begin
      rd_word = '0;
      if (in_range) begin
         rd_word = mem_q[idx];
      end
   end

   always_comb begin
      o_data_d = o_data_q;
      if (!bus.i_wr_en) begin
         o_data_d = rd_word;
      end
`ifdef REG_FILE_WRITE_THROUGH_EN
      else if (in_range) begin
         o_data_d = bus.i_data;
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mem_q <= '{default: '0};
      end else if (wr_hit) begin
         mem_q[idx] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_data_q <= '0;
      end else begin
         o_data_q <= o_data_d;
      end
   end

   assign bus.o_data = o_data_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: a default 256-word instance
// and a 64-word instance for out-of-range behaviour.
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   reg_file_if #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) bus ();
   reg_file_if #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) b64 ();

   reg_file #(.DATA_WIDTH(8), .LENGTH(256), .ADDRESS_SIZE(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   reg_file #(.DATA_WIDTH(8), .LENGTH(64), .ADDRESS_SIZE(8)) dut64 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic op(input logic wr, input logic [7:0] a, input logic [7:0] d);
      bus.i_wr_en   = wr;
      bus.i_address = a;
      bus.i_data    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic op64(input logic wr, input logic [7:0] a, input logic [7:0] d);
      b64.i_wr_en   = wr;
      b64.i_address = a;
      b64.i_data    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      op(1'b1, 8'h02, 8'hAB);
      op(1'b1, 8'h02, 8'hAB);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_odata got=%h exp=00", bus.o_data); end
      checks++;
      if (b64.o_data !== 8'h00) begin errors++; $display("FAIL rst_odata64 got=%h exp=00", b64.o_data); end
      rst_n = 1'b1;
      op(1'b0, 8'h00, 8'h00);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_rd00 got=%h exp=00", bus.o_data); end
      op(1'b0, 8'h02, 8'h00);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_rd02 got=%h exp=00", bus.o_data); end
      op(1'b0, 8'hA6, 8'h00);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL rst_rdA6 got=%h exp=00", bus.o_data); end
   endtask

   task automatic test_write_read;
      op(1'b1, 8'h02, 8'h15);
`ifdef REG_FILE_WRITE_THROUGH_EN
      checks++;
      if (bus.o_data !== 8'h15) begin errors++; $display("FAIL wr02_odata got=%h exp=15", bus.o_data); end
`else
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL wr02_hold got=%h exp=00", bus.o_data); end
`endif
      op(1'b1, 8'hA6, 8'h99);
      op(1'b0, 8'h02, 8'h84);
      checks++;
      if (bus.o_data !== 8'h15) begin errors++; $display("FAIL rd02 got=%h exp=15", bus.o_data); end
      op(1'b0, 8'h02, 8'h00);
      checks++;
      if (bus.o_data !== 8'h15) begin errors++; $display("FAIL rd02_again got=%h exp=15", bus.o_data); end
      op(1'b0, 8'hA6, 8'h00);
      checks++;
      if (bus.o_data !== 8'h99) begin errors++; $display("FAIL rdA6 got=%h exp=99", bus.o_data); end
   endtask

   task automatic test_overwrite;
      op(1'b1, 8'hA6, 8'hFF);
      op(1'b0, 8'hA6, 8'hEA);
      checks++;
      if (bus.o_data !== 8'hFF) begin errors++; $display("FAIL ovw_rdA6 got=%h exp=ff", bus.o_data); end
      op(1'b1, 8'h03, 8'h80);
      op(1'b1, 8'h04, 8'h7F);
      op(1'b0, 8'h03, 8'h00);
      checks++;
      if (bus.o_data !== 8'h80) begin errors++; $display("FAIL msb_rd03 got=%h exp=80", bus.o_data); end
      op(1'b0, 8'h04, 8'h00);
      checks++;
      if (bus.o_data !== 8'h7F) begin errors++; $display("FAIL lsb_rd04 got=%h exp=7f", bus.o_data); end
      op(1'b0, 8'hA6, 8'h00);
   endtask

   task automatic test_back_to_back;
      op(1'b1, 8'h10, 8'h5A);
`ifdef REG_FILE_WRITE_THROUGH_EN
      checks++;
      if (bus.o_data !== 8'h5A) begin errors++; $display("FAIL b2b_wt got=%h exp=5a", bus.o_data); end
`else
      checks++;
      if (bus.o_data !== 8'hFF) begin errors++; $display("FAIL b2b_hold got=%h exp=ff", bus.o_data); end
`endif
      op(1'b0, 8'h10, 8'h00);
      checks++;
      if (bus.o_data !== 8'h5A) begin errors++; $display("FAIL b2b_rd10 got=%h exp=5a", bus.o_data); end
   endtask

   task automatic test_reset_mid;
      op(1'b1, 8'h21, 8'h44);
      op(1'b0, 8'h21, 8'h00);
      checks++;
      if (bus.o_data !== 8'h44) begin errors++; $display("FAIL pre_rd21 got=%h exp=44", bus.o_data); end
      rst_n = 1'b0;
      op(1'b1, 8'h20, 8'h77);
      rst_n = 1'b1;
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL mid_rst_odata got=%h exp=00", bus.o_data); end
      op(1'b0, 8'h20, 8'h00);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL mid_rd20 got=%h exp=00", bus.o_data); end
      op(1'b0, 8'h21, 8'h00);
      checks++;
      if (bus.o_data !== 8'h00) begin errors++; $display("FAIL mid_rd21 got=%h exp=00", bus.o_data); end
      op(1'b1, 8'h20, 8'h66);
      op(1'b0, 8'h20, 8'h00);
      checks++;
      if (bus.o_data !== 8'h66) begin errors++; $display("FAIL post_rd20 got=%h exp=66", bus.o_data); end
   endtask

   task automatic test_out_of_range;
      op64(1'b1, 8'h05, 8'h11);
      op64(1'b0, 8'h05, 8'h00);
      checks++;
      if (b64.o_data !== 8'h11) begin errors++; $display("FAIL oor_rd05 got=%h exp=11", b64.o_data); end
      op64(1'b1, 8'hA6, 8'h33);
      checks++;
      if (b64.o_data !== 8'h11) begin errors++; $display("FAIL oor_wr_hold got=%h exp=11", b64.o_data); end
      op64(1'b0, 8'hA6, 8'h00);
      checks++;
      if (b64.o_data !== 8'h00) begin errors++; $display("FAIL oor_rdA6 got=%h exp=00", b64.o_data); end
      op64(1'b0, 8'h26, 8'h00);
      checks++;
      if (b64.o_data !== 8'h00) begin errors++; $display("FAIL oor_rd26 got=%h exp=00", b64.o_data); end
      op64(1'b0, 8'h05, 8'h00);
      checks++;
      if (b64.o_data !== 8'h11) begin errors++; $display("FAIL oor_rd05b got=%h exp=11", b64.o_data); end
      op64(1'b1, 8'h3F, 8'h22);
      op64(1'b0, 8'h3F, 8'h00);
      checks++;
      if (b64.o_data !== 8'h22) begin errors++; $display("FAIL oor_rd3F got=%h exp=22", b64.o_data); end
      op64(1'b1, 8'h40, 8'h55);
      op64(1'b0, 8'h40, 8'h00);
      checks++;
      if (b64.o_data !== 8'h00) begin errors++; $display("FAIL oor_rd40 got=%h exp=00", b64.o_data); end
      op64(1'b0, 8'h00, 8'h00);
      checks++;
      if (b64.o_data !== 8'h00) begin errors++; $display("FAIL oor_rd00 got=%h exp=00", b64.o_data); end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst_n         = 1'b0;
      bus.i_wr_en   = 1'b0;
      bus.i_address = '0;
      bus.i_data    = '0;
      b64.i_wr_en   = 1'b0;
      b64.i_address = '0;
      b64.i_data    = '0;
      #1;
      test_reset();
      test_write_read();
      test_overwrite();
      test_back_to_back();
      test_reset_mid();
      test_out_of_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
